// File: rtl/task_result_tx.sv
// UART 8N1 transmitter for task result streams. A small FIFO absorbs the
// non-stallable byte stream, and an optional delimiter byte follows each packet.
module task_result_tx #(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CLKS_PER_BIT = 868,
  parameter bit         EOP_EN       = 1'b1,
  parameter logic [7:0] EOP_BYTE     = 8'h0A
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  input  logic                          i_last,
  input  logic [7:0]                    i_data,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          full, push, pop;
  logic [8:0]    head;

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          last_q, last_d;
  logic [7:0]    sh_q, sh_d;
  logic          baud_done;

  // Full is judged on the registered count, so a same-cycle pop never frees room
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign push = i_valid && !full;
  assign head = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_last, i_data};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (i_valid && full) overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---- Transmit FSM ----
  assign baud_done = (cnt_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    last_d  = last_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = head[7:0];
          last_d  = head[8];
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_d = '0;
          // Clearing last on the delimiter keeps it from chaining another one
          if (last_q && EOP_EN) begin
            sh_d    = EOP_BYTE;
            last_d  = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge i_clk) begin
    sh_q <= sh_d;
  end

  always_comb begin
    o_tx = 1'b1;
    if (state_q == START)     o_tx = 1'b0;
    else if (state_q == DATA) o_tx = sh_q[0];
  end

  assign o_busy       = (state_q != IDLE) | (count_q != '0);
  assign o_overflow   = overflow_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_task_result_tx.sv
// Bench for task_result_tx: two instances (delimiter on / off) share one stimulus
// and are compared every cycle against a frame-level queue model.
module tb_task_result_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic       clk;
  logic       rst_n;
  logic       vld;
  logic       last;
  logic [7:0] data;

  logic       tx_w   [2];
  logic       busy_w [2];
  logic       ovf_w  [2];
  logic [2:0] cnt_w  [2];

  int checks;
  int errors;
  int cur;
  bit armed;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", nm, $time, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit EOPV = (g == 1);

    logic [8:0] fq [$];
    bit         txq [$];
    bit         ovf_m;
    logic [7:0] flog [$];

    task_result_tx #(
      .FIFO_DEPTH  (DEPTH),
      .CLKS_PER_BIT(CPB),
      .EOP_EN      (EOPV),
      .EOP_BYTE    (8'h0A)
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (vld),
      .i_last      (last),
      .i_data      (data),
      .o_tx        (tx_w[g]),
      .o_busy      (busy_w[g]),
      .o_overflow  (ovf_w[g]),
      .o_fifo_count(cnt_w[g])
    );

    // Model: the line is a queue of future bit values; an idle line takes the
    // FIFO head and appends whole frames (plus the delimiter frame when due).
    always @(posedge clk or negedge rst_n) begin : model
      int         n_pre;
      int         nf;
      bit         idle;
      logic [8:0] e;
      logic [7:0] b;
      if (!rst_n) begin
        fq.delete();
        txq.delete();
        flog.delete();
        ovf_m = 1'b0;
      end else begin
        n_pre = fq.size();
        idle  = (txq.size() == 0);
        if (!idle) void'(txq.pop_front());
        if (idle && n_pre != 0) begin
          e  = fq.pop_front();
          nf = (e[8] && EOPV) ? 2 : 1;
          for (int f = 0; f < nf; f++) begin
            b = (f == 0) ? e[7:0] : 8'h0A;
            flog.push_back(b);
            for (int k = 0; k < 10; k++)
              for (int c = 0; c < CPB; c++)
                txq.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
          end
        end
        if (vld) begin
          if (n_pre < DEPTH) fq.push_back({last, data});
          else               ovf_m = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("cyc_tx[%0d]", g),    tx_w[g],   (txq.size() != 0) ? int'(txq[0]) : 1);
        chk($sformatf("cyc_busy[%0d]", g),  busy_w[g], int'(txq.size() != 0 || fq.size() != 0));
        chk($sformatf("cyc_ovf[%0d]", g),   ovf_w[g],  ovf_m);
        chk($sformatf("cyc_count[%0d]", g), cnt_w[g],  fq.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic goto_cyc(input int k);
    while (cur < k) tick();
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    vld  = 1'b1;
    data = d;
    last = l;
    tick();
    vld  = 1'b0;
    last = 1'b0;
  endtask

  task automatic do_reset();
    vld   = 1'b0;
    last  = 1'b0;
    data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur   = 0;
  endtask

  task automatic chk_log(input string nm, input int which, input logic [39:0] exp, input int n);
    int sz;
    sz = (which == 1) ? g_inst[1].flog.size() : g_inst[0].flog.size();
    chk({nm, "_len"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) begin
        if (which == 1) chk({nm, "_byte"}, g_inst[1].flog[i], exp[8*(n-1-i) +: 8]);
        else            chk({nm, "_byte"}, g_inst[0].flog[i], exp[8*(n-1-i) +: 8]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_bits;
    int         peak;
    vld = 1'b0; last = 1'b0; data = 8'h00; rst_n = 1'b1;
    cur = 0; armed = 1'b0; checks = 0; errors = 0;
    #3;
    do_reset();
    armed = 1'b1;

    // Reset state
    chk("rst_tx", tx_w[1], 1);
    chk("rst_busy", busy_w[1], 0);
    chk("rst_ovf", ovf_w[1], 0);
    chk("rst_count", cnt_w[1], 0);

    // Single byte A5, last=0
    cur = 0;
    put(8'hA5, 1'b0);
    chk("a5_count_c1", cnt_w[1], 1);
    chk("a5_tx_c1", tx_w[1], 1);
    goto_cyc(2);
    chk("a5_start_c2", tx_w[1], 0);
    chk("a5_start_c2_noeop", tx_w[0], 0);
    exp_bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      goto_cyc(7 + 4*i);
      chk("a5_bit", tx_w[1], exp_bits[i]);
    end
    goto_cyc(39);
    chk("a5_stop", tx_w[1], 1);
    goto_cyc(41);
    chk("a5_busy_c41", busy_w[1], 1);
    goto_cyc(42);
    chk("a5_busy_c42", busy_w[1], 0);
    chk("a5_busy_c42_noeop", busy_w[0], 0);
    chk_log("a5_log1", 1, 40'hA5, 1);
    chk_log("a5_log0", 0, 40'hA5, 1);

    // Byte 31 with last=1: delimiter follows with no gap only when enabled
    do_reset();
    put(8'h31, 1'b1);
    goto_cyc(41);
    chk("eop_stop_c41", tx_w[1], 1);
    goto_cyc(42);
    chk("eop_start_c42", tx_w[1], 0);
    chk("noeop_idle_tx_c42", tx_w[0], 1);
    chk("noeop_busy_c42", busy_w[0], 0);
    goto_cyc(47);
    chk("eop_bit0", tx_w[1], 0);
    goto_cyc(51);
    chk("eop_bit1", tx_w[1], 1);
    goto_cyc(81);
    chk("eop_busy_c81", busy_w[1], 1);
    goto_cyc(82);
    chk("eop_busy_c82", busy_w[1], 0);
    chk_log("eop_log1", 1, {8'h31, 8'h0A}, 2);
    chk_log("eop_log0", 0, 40'h31, 1);

    // Burst of six bytes into a depth-4 FIFO
    do_reset();
    peak = 0;
    for (int i = 1; i <= 6; i++) begin
      put(8'(i), 1'b0);
      if (int'(cnt_w[1]) > peak) peak = int'(cnt_w[1]);
      if (cur == 5) begin
        chk("burst_count_c5", cnt_w[1], 4);
        chk("burst_ovf_c5", ovf_w[1], 0);
      end
    end
    chk("burst_ovf_c6", ovf_w[1], 1);
    while (cur < 205) begin
      tick();
      if (int'(cnt_w[1]) > peak) peak = int'(cnt_w[1]);
    end
    chk("burst_busy_c205", busy_w[1], 1);
    tick();
    chk("burst_busy_c206", busy_w[1], 0);
    chk("burst_ovf_sticky", ovf_w[1], 1);
    chk("burst_peak", peak, 4);
    chk_log("burst_log1", 1, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 5);
    chk_log("burst_log0", 0, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 5);

    // Push coinciding with a pop at count 3
    do_reset();
    put(8'h11, 1'b0);
    put(8'h12, 1'b0);
    put(8'h13, 1'b0);
    put(8'h14, 1'b0);
    goto_cyc(42);
    chk("pp_count_c42", cnt_w[1], 3);
    put(8'h15, 1'b0);
    chk("pp_count_c43", cnt_w[1], 3);
    chk("pp_start_c43", tx_w[1], 0);
    chk("pp_ovf", ovf_w[1], 0);
    goto_cyc(206);
    chk("pp_busy_c206", busy_w[1], 0);
    chk_log("pp_log1", 1, {8'h11, 8'h12, 8'h13, 8'h14, 8'h15}, 5);

    // Reset asserted during the data bits of a frame
    do_reset();
    for (int i = 1; i <= 6; i++) put(8'(i), 1'b0);
    goto_cyc(12);
    chk("mr_tx_before", tx_w[1], 0);
    chk("mr_ovf_before", ovf_w[1], 1);
    chk("mr_count_before", cnt_w[1], 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_tx_async", tx_w[1], 1);
    chk("mr_count_async", cnt_w[1], 0);
    chk("mr_ovf_async", ovf_w[1], 0);
    chk("mr_busy_async", busy_w[1], 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (60) tick();
    chk("mr_tx_after", tx_w[1], 1);
    chk("mr_busy_after", busy_w[1], 0);
    chk("mr_tx_after_noeop", tx_w[0], 1);
    chk("mr_busy_after_noeop", busy_w[0], 0);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
